// File: rtl/byte_gearbox_pkg.sv
// Shared types and width helpers for the byte gearbox FIFO and its ring storage.
package byte_gearbox_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  // Width of a byte count that can hold 0..lanes inclusive.
  function automatic int unsigned lanes_to_nw(input int unsigned lanes);
    return $clog2(lanes + 1);
  endfunction

  // Pointer width for a power-of-two byte ring; at least one bit.
  function automatic int unsigned depth_to_ptrw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/byte_gearbox_fifo_if.sv
// Write/read handshake bundle between the fragment parser, the gearbox FIFO and the packer.
interface byte_gearbox_fifo_if
  import byte_gearbox_pkg::*;
#(
  parameter int unsigned IN_LANES    = 4,
  parameter int unsigned OUT_LANES   = 4,
  parameter int unsigned DEPTH_BYTES = 64
) ();

  localparam int unsigned IN_NW  = lanes_to_nw(IN_LANES);
  localparam int unsigned OUT_NW = lanes_to_nw(OUT_LANES);
  localparam int unsigned LVL_W  = lanes_to_nw(DEPTH_BYTES);

  logic                        wr_en;
  logic [IN_LANES*BYTE_W-1:0]  wr_data;
  logic [IN_NW-1:0]            wr_nbytes;
  logic                        wr_ready;
  logic                        rd_en;
  logic [OUT_NW-1:0]           rd_nbytes;
  logic [OUT_LANES*BYTE_W-1:0] rd_data;
  logic                        rd_valid;
  logic [LVL_W-1:0]            level;
  logic                        ovf_err;
  logic                        udf_err;
  logic                        err_clr;

  modport master (
    output wr_en, wr_data, wr_nbytes, rd_en, rd_nbytes, err_clr,
    input  wr_ready, rd_data, rd_valid, level, ovf_err, udf_err
  );

  modport slave (
    input  wr_en, wr_data, wr_nbytes, rd_en, rd_nbytes, err_clr,
    output wr_ready, rd_data, rd_valid, level, ovf_err, udf_err
  );

endinterface

// File: rtl/byte_gearbox_ring.sv
// Byte-addressed circular RAM: multi-byte write at a base pointer, combinational
// OUT_LANES-wide read window starting at rd_ptr; both wrap at DEPTH_BYTES.
module byte_gearbox_ring
  import byte_gearbox_pkg::*;
#(
  parameter int unsigned IN_LANES    = 4,
  parameter int unsigned OUT_LANES   = 4,
  parameter int unsigned DEPTH_BYTES = 64,
  parameter int unsigned PTR_W       = depth_to_ptrw(DEPTH_BYTES),
  parameter int unsigned IN_NW       = lanes_to_nw(IN_LANES)
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [PTR_W-1:0]            wr_ptr,
  input  logic [IN_NW-1:0]            wr_n,
  input  logic [IN_LANES*BYTE_W-1:0]  wr_data,
  input  logic [PTR_W-1:0]            rd_ptr,
  output logic [OUT_LANES*BYTE_W-1:0] rd_window
);

  byte_t mem [DEPTH_BYTES];

  // Lane i (counted from the MSB) lands at wr_ptr+i; storage is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < IN_LANES; i++) begin
        if (IN_NW'(i) < wr_n) begin
          mem[PTR_W'(wr_ptr + PTR_W'(i))] <= wr_data[(IN_LANES-i)*BYTE_W-1 -: BYTE_W];
        end
      end
    end
  end

  always_comb begin
    rd_window = '0;
    for (int unsigned j = 0; j < OUT_LANES; j++) begin
      rd_window[(OUT_LANES-j)*BYTE_W-1 -: BYTE_W] = mem[PTR_W'(rd_ptr + PTR_W'(j))];
    end
  end

endmodule

// File: rtl/byte_gearbox_fifo.sv
// Byte-granular gearbox FIFO: 0..IN_LANES bytes in per beat, 0..OUT_LANES bytes out per read.
// Optional build macro BYTE_GEARBOX_FLUSH_EN adds a synchronous flush input.
module byte_gearbox_fifo
  import byte_gearbox_pkg::*;
#(
  parameter int unsigned IN_LANES    = 4,
  parameter int unsigned OUT_LANES   = 4,
  parameter int unsigned DEPTH_BYTES = 64
) (
  input  logic clk,
  input  logic rst_n,
`ifdef BYTE_GEARBOX_FLUSH_EN
  input  logic flush,
`endif
  byte_gearbox_fifo_if.slave bus
);

  localparam int unsigned IN_NW  = lanes_to_nw(IN_LANES);
  localparam int unsigned OUT_NW = lanes_to_nw(OUT_LANES);
  localparam int unsigned LVL_W  = lanes_to_nw(DEPTH_BYTES);
  localparam int unsigned LVL_XW = LVL_W + 1;
  localparam int unsigned PTR_W  = depth_to_ptrw(DEPTH_BYTES);
  localparam int unsigned CMP_W  = LVL_W + OUT_NW;
  localparam int unsigned DATA_W = OUT_LANES * BYTE_W;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              flush_req;
  logic [LVL_XW-1:0] free_bytes;
  logic              wr_ready_c;
  logic              wr_fit, rd_fit;
  logic              wr_acc, wr_drop, rd_acc, rd_rej;
  logic [IN_NW-1:0]  wr_n;
  logic [OUT_NW-1:0] rd_n;
  logic [DATA_W-1:0] rd_window;
  logic [DATA_W-1:0] rd_masked;

`ifdef BYTE_GEARBOX_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Space check uses the registered level only; a same-cycle read earns no credit.
  assign free_bytes = LVL_XW'(DEPTH_BYTES) - LVL_XW'(level_q);
  assign wr_ready_c = free_bytes >= LVL_XW'(IN_LANES);

  assign wr_fit  = wr_ready_c && (bus.wr_nbytes <= IN_NW'(IN_LANES));
  assign rd_fit  = (CMP_W'(bus.rd_nbytes) <= CMP_W'(level_q)) &&
                   (bus.rd_nbytes <= OUT_NW'(OUT_LANES));

  // Flush outranks both ports: nothing is accepted and nothing is flagged.
  assign wr_acc  = bus.wr_en && wr_fit  && !flush_req;
  assign wr_drop = bus.wr_en && !wr_fit && !flush_req;
  assign rd_acc  = bus.rd_en && rd_fit  && !flush_req;
  assign rd_rej  = bus.rd_en && !rd_fit && !flush_req;

  assign wr_n = wr_acc ? bus.wr_nbytes : '0;
  assign rd_n = rd_acc ? bus.rd_nbytes : '0;

  byte_gearbox_ring #(
    .IN_LANES    (IN_LANES),
    .OUT_LANES   (OUT_LANES),
    .DEPTH_BYTES (DEPTH_BYTES),
    .PTR_W       (PTR_W),
    .IN_NW       (IN_NW)
  ) u_ring (
    .clk       (clk),
    .wr_en     (wr_acc),
    .wr_ptr    (wr_ptr_q),
    .wr_n      (bus.wr_nbytes),
    .wr_data   (bus.wr_data),
    .rd_ptr    (rd_ptr_q),
    .rd_window (rd_window)
  );

  // Keep only the requested leading lanes; the rest of the word reads as zero.
  always_comb begin
    rd_masked = '0;
    for (int unsigned j = 0; j < OUT_LANES; j++) begin
      if (OUT_NW'(j) < bus.rd_nbytes) begin
        rd_masked[(OUT_LANES-j)*BYTE_W-1 -: BYTE_W] = rd_window[(OUT_LANES-j)*BYTE_W-1 -: BYTE_W];
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;

    // Clear first so that a fresh error in the same cycle wins.
    if (bus.err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_drop) ovf_d = 1'b1;
    if (rd_rej)  udf_d = 1'b1;

    if (wr_acc) wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(bus.wr_nbytes));
    if (rd_acc) begin
      rd_ptr_d   = PTR_W'(rd_ptr_q + PTR_W'(bus.rd_nbytes));
      rd_data_d  = rd_masked;
      rd_valid_d = 1'b1;
    end

    level_d = LVL_W'(LVL_XW'(level_q) - LVL_XW'(rd_n) + LVL_XW'(wr_n));

    if (flush_req) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign bus.wr_ready = wr_ready_c;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.level    = level_q;
  assign bus.ovf_err  = ovf_q;
  assign bus.udf_err  = udf_q;

endmodule

// File: tb/tb_byte_gearbox_fifo.sv
// Scoreboard bench for byte_gearbox_fifo: reads push expected words, a negedge monitor checks them.
// Flush scenario is compiled in when BYTE_GEARBOX_FLUSH_EN is defined.
module tb_byte_gearbox_fifo;
  import byte_gearbox_pkg::*;

  localparam int unsigned IN_LANES    = 4;
  localparam int unsigned OUT_LANES   = 4;
  localparam int unsigned DEPTH_BYTES = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef BYTE_GEARBOX_FLUSH_EN
  logic flush = 1'b0;
`endif

  byte_gearbox_fifo_if #(
    .IN_LANES(IN_LANES), .OUT_LANES(OUT_LANES), .DEPTH_BYTES(DEPTH_BYTES)
  ) bus ();

  byte_gearbox_fifo #(
    .IN_LANES(IN_LANES), .OUT_LANES(OUT_LANES), .DEPTH_BYTES(DEPTH_BYTES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef BYTE_GEARBOX_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Four consecutive byte values starting at 4*k, first byte in the MSB lane.
  function automatic logic [31:0] pat(input int k);
    logic [7:0] b;
    b = 8'(4 * k);
    return {b, 8'(b + 8'd1), 8'(b + 8'd2), 8'(b + 8'd3)};
  endfunction

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rd_valid: got rd_data %h, expected no read", bus.rd_data);
      end else begin
        chk("rd_data", bus.rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] data, input int n);
    bus.wr_en     = 1'b1;
    bus.wr_data   = data;
    bus.wr_nbytes = 3'(n);
    cyc();
    bus.wr_en     = 1'b0;
  endtask

  task automatic rd_ok(input int n, input logic [31:0] exp);
    bus.rd_en     = 1'b1;
    bus.rd_nbytes = 3'(n);
    exp_q.push_back(exp);
    cyc();
    bus.rd_en     = 1'b0;
  endtask

  task automatic rd_bad(input int n);
    bus.rd_en     = 1'b1;
    bus.rd_nbytes = 3'(n);
    cyc();
    bus.rd_en     = 1'b0;
  endtask

  task automatic wrrd(input logic [31:0] wdata, input int wn, input int rn, input logic [31:0] rexp);
    bus.wr_en     = 1'b1;
    bus.wr_data   = wdata;
    bus.wr_nbytes = 3'(wn);
    bus.rd_en     = 1'b1;
    bus.rd_nbytes = 3'(rn);
    exp_q.push_back(rexp);
    cyc();
    bus.wr_en     = 1'b0;
    bus.rd_en     = 1'b0;
  endtask

  task automatic clear_errs();
    bus.err_clr = 1'b1;
    cyc();
    bus.err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_nbytes = '0;
    bus.rd_en = 1'b0; bus.rd_nbytes = '0; bus.err_clr = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    chk("rst_level",    32'(bus.level),    32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data",  bus.rd_data,       32'h0);
    chk("rst_ovf",      32'(bus.ovf_err),  32'd0);
    chk("rst_udf",      32'(bus.udf_err),  32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);

    // Partial writes and reads straddling beat boundaries
    wr(32'hAABBCCDD, 4);
    wr(32'h11223344, 2);
    chk("t1_level6", 32'(bus.level), 32'd6);
    rd_ok(3, 32'hAABBCC00);
    chk("t1_level3", 32'(bus.level), 32'd3);
    rd_ok(3, 32'hDD112200);
    chk("t1_level0", 32'(bus.level), 32'd0);

    // Fill to capacity, overflow, clear
    for (int k = 0; k < 15; k++) wr(pat(k), 4);
    chk("t2_level60",   32'(bus.level),    32'd60);
    chk("t2_ready60",   32'(bus.wr_ready), 32'd1);
    wr(pat(15), 4);
    chk("t2_level64",   32'(bus.level),    32'd64);
    chk("t2_ready64",   32'(bus.wr_ready), 32'd0);
    wr(32'hDEADBEEF, 4);
    chk("t2_ovf_set",   32'(bus.ovf_err),  32'd1);
    chk("t2_level_hold",32'(bus.level),    32'd64);
    clear_errs();
    chk("t2_ovf_clr",   32'(bus.ovf_err),  32'd0);
    for (int k = 0; k < 16; k++) rd_ok(4, pat(k));
    chk("t2_drained",   32'(bus.level),    32'd0);
    wr(32'h99999999, 5);
    chk("t2_ovf_nbytes",32'(bus.ovf_err),  32'd1);
    chk("t2_lvl_nbytes",32'(bus.level),    32'd0);
    clear_errs();

    // Underflow rejection, set-wins-over-clear, zero-byte read, lane bound
    wr(32'h55667788, 2);
    chk("t3_level2",    32'(bus.level),    32'd2);
    rd_bad(3);
    chk("t3_no_valid",  32'(bus.rd_valid), 32'd0);
    chk("t3_data_hold", bus.rd_data,       32'h3C3D3E3F);
    chk("t3_udf_set",   32'(bus.udf_err),  32'd1);
    chk("t3_level_hold",32'(bus.level),    32'd2);
    rd_ok(2, 32'h55660000);
    chk("t3_level0",    32'(bus.level),    32'd0);
    bus.err_clr = 1'b1;
    rd_bad(1);
    bus.err_clr = 1'b0;
    chk("t3_set_wins",  32'(bus.udf_err),  32'd1);
    clear_errs();
    chk("t3_udf_clr",   32'(bus.udf_err),  32'd0);
    rd_ok(0, 32'h0);
    wr(32'h10111213, 4);
    wr(32'h14151617, 4);
    rd_bad(5);
    chk("t3_udf_lanes", 32'(bus.udf_err),  32'd1);
    chk("t3_level8",    32'(bus.level),    32'd8);
    rd_ok(4, 32'h10111213);
    rd_ok(4, 32'h14151617);
    clear_errs();

    // Walk pointers from 16 to 58, then straddle the 63->0 wrap
    for (int k = 0; k < 10; k++) begin
      wr(pat(k + 32), 4);
      rd_ok(4, pat(k + 32));
    end
    wr(32'hEEFF0000, 2);
    rd_ok(2, 32'hEEFF0000);
    wr(32'hA0A1A2A3, 4);
    chk("t4_level4a",   32'(bus.level),    32'd4);
    wrrd(32'h01020304, 4, 4, 32'hA0A1A2A3);
    chk("t4_level4b",   32'(bus.level),    32'd4);
    rd_ok(4, 32'h01020304);
    chk("t4_level0",    32'(bus.level),    32'd0);

    // Reset in the middle of traffic with a read request pending
    wr(32'h21222324, 4);
    wr(32'h25262728, 4);
    wr(32'h292A0000, 2);
    chk("t5_level10",   32'(bus.level),    32'd10);
    wr(32'h0, 5);
    chk("t5_ovf_pre",   32'(bus.ovf_err),  32'd1);
    bus.rd_en = 1'b1;
    bus.rd_nbytes = 3'd4;
    rst_n = 1'b0;
    cyc();
    bus.rd_en = 1'b0;
    rst_n = 1'b1;
    chk("t5_level",     32'(bus.level),    32'd0);
    chk("t5_rd_valid",  32'(bus.rd_valid), 32'd0);
    chk("t5_ovf",       32'(bus.ovf_err),  32'd0);
    chk("t5_udf",       32'(bus.udf_err),  32'd0);
    chk("t5_wr_ready",  32'(bus.wr_ready), 32'd1);
    chk("t5_rd_data",   bus.rd_data,       32'h0);

`ifdef BYTE_GEARBOX_FLUSH_EN
    // Flush beats a simultaneous read and write
    for (int k = 0; k < 5; k++) wr(pat(k + 8), 4);
    chk("t6_level20",   32'(bus.level),    32'd20);
    flush = 1'b1;
    bus.wr_en = 1'b1; bus.wr_data = 32'h77777777; bus.wr_nbytes = 3'd4;
    bus.rd_en = 1'b1; bus.rd_nbytes = 3'd4;
    cyc();
    flush = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    chk("t6_level0",    32'(bus.level),    32'd0);
    chk("t6_rd_valid",  32'(bus.rd_valid), 32'd0);
    chk("t6_ovf",       32'(bus.ovf_err),  32'd0);
    chk("t6_udf",       32'(bus.udf_err),  32'd0);
    wr(32'hCAFEBABE, 4);
    rd_ok(4, 32'hCAFEBABE);
    chk("t6_level_end", 32'(bus.level),    32'd0);
`endif

    cyc(); cyc(); cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
